// File: rtl/data_sram_like_bridge_if.sv
// ----------------------------------------------------------------------------
// data_sram_like_bridge_if
//
// Purpose:
//   Bundles both faces of the data SRAM bridge into one interface. The first
//   face is the CPU core's single-cycle data SRAM port plus the pipeline
//   stall handshake. The second face is the two-phase sram-like bus
//   (req / addr_ok / data_ok).
//
// Modports:
//   master : the bridge itself. It consumes the CPU request, drives read data
//            and d_stall back to the CPU, and masters the sram-like bus.
//   slave  : the environment. This is the CPU core together with the bus
//            slave: it drives the CPU request and the bus responses.
//
// Signals (names follow the CPU / bus naming):
//   data_sram_en      CPU access request, level-held while stalled
//   data_sram_wen     byte write enables, 0 = read
//   data_sram_addr    CPU physical address
//   data_sram_wdata   CPU write data, byte-lane aligned
//   data_sram_rdata   read data returned to the CPU
//   longest_stall     OR of every other pipeline stall
//   d_stall           stall request from the bridge
//   data_req          bus request
//   data_wr           1 = write
//   data_size         0 = byte, 1 = half, 2 = word
//   data_addr         bus address
//   data_wdata        bus write data
//   data_addr_ok      bus accepted the address
//   data_data_ok      bus completed the transfer
//   data_rdata        bus read data
// ----------------------------------------------------------------------------
interface data_sram_like_bridge_if #(
    parameter int ADDR_W = 32
);
    // CPU side
    logic              data_sram_en;
    logic [3:0]        data_sram_wen;
    logic [ADDR_W-1:0] data_sram_addr;
    logic [31:0]       data_sram_wdata;
    logic [31:0]       data_sram_rdata;
    logic              longest_stall;
    logic              d_stall;

    // sram-like bus side
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        input  longest_stall,
        output data_sram_rdata,
        output d_stall,
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        output longest_stall,
        input  data_sram_rdata,
        input  d_stall,
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/data_sram_like_bridge.sv
// ----------------------------------------------------------------------------
// data_sram_like_bridge
//
// Purpose:
//   This block sits between the CPU core's single-cycle data SRAM port and a
//   two-phase sram-like bus. Each CPU access becomes exactly one bus
//   transaction. The pipeline is stalled until that transaction completes.
//   Read data is then held until the rest of the pipeline lets go, so the
//   datapath never sees the bus latency.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-high
//   bus      ---  data_sram_like_bridge_if.master (CPU port, stall handshake,
//                 and sram-like bus)
//   bus_err  out  sticky watchdog flag (present only with DBRIDGE_TIMEOUT_EN)
//
// Parameters:
//   ADDR_W          address width on both sides
//   TIMEOUT_CYCLES  watchdog limit in cycles (present only with
//                   DBRIDGE_TIMEOUT_EN)
//
// Build option:
//   DBRIDGE_TIMEOUT_EN  When this macro is defined, a watchdog is added. It
//                       aborts a transaction that has sat in REQ/WAIT for
//                       TIMEOUT_CYCLES cycles. It then returns 32'hDEADBEEF
//                       and raises bus_err. When the macro is undefined, the
//                       bridge waits indefinitely.
//
// FSM states:
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no access in flight; a CPU request is latched here
//   REQ   | data_req high, waiting for addr_ok
//   WAIT  | address accepted, waiting for data_ok
//   DONE  | transfer finished, rdata held until longest_stall drops
// ----------------------------------------------------------------------------
module data_sram_like_bridge #(
    parameter int ADDR_W = 32
`ifdef DBRIDGE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic clk,
    input  logic rst,
`ifdef DBRIDGE_TIMEOUT_EN
    output logic bus_err,
`endif
    data_sram_like_bridge_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;

    logic              w_wr;
    logic [1:0]        w_size;
    logic [1:0]        w_addr_lo;
    logic              w_latch;
    logic              w_capture;
    logic              w_expire;
    logic              w_timeout;

    // ------------------------------------------------------------------------
    // Byte-enable to size/low-address translation.
    // The CPU marks a sub-word write only through wen, so the bus address low
    // bits are rebuilt from the enabled lanes. Reads keep the CPU address as
    // given. Irregular lane patterns fall back to a full-word write; wen
    // still selects the bytes in the slave.
    // ------------------------------------------------------------------------
    always_comb begin
        w_wr      = |bus.data_sram_wen;
        w_size    = 2'd2;
        w_addr_lo = 2'b00;
        case (bus.data_sram_wen)
            4'b0000: w_addr_lo = bus.data_sram_addr[1:0];
            4'b0011: begin w_size = 2'd1; w_addr_lo = 2'b00; end
            4'b1100: begin w_size = 2'd1; w_addr_lo = 2'b10; end
            4'b0001: begin w_size = 2'd0; w_addr_lo = 2'b00; end
            4'b0010: begin w_size = 2'd0; w_addr_lo = 2'b01; end
            4'b0100: begin w_size = 2'd0; w_addr_lo = 2'b10; end
            4'b1000: begin w_size = 2'd0; w_addr_lo = 2'b11; end
            default: begin w_size = 2'd2; w_addr_lo = 2'b00; end
        endcase
    end

    // ------------------------------------------------------------------------
    // Optional watchdog: a down-counter loaded as the FSM leaves IDLE.
    // It counts through REQ and WAIT. Hitting zero while still waiting aborts
    // the access.
    // ------------------------------------------------------------------------
`ifdef DBRIDGE_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] r_tmr;
    logic             r_bus_err;
    logic             w_busy;

    assign w_busy    = (r_state == ST_REQ) || (r_state == ST_WAIT);
    assign w_timeout = w_busy && (r_tmr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_latch) begin
                r_tmr <= TMR_LOAD;
            end else if (w_busy && (r_tmr != '0)) begin
                r_tmr <= r_tmr - TMR_W'(1);
            end
            if (w_expire) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and control strobes.
    // A real completion (data_ok) always wins over a watchdog expiry in the
    // same cycle. Bus responses in IDLE/DONE are not looked at.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_capture   = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.data_sram_en) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.data_addr_ok && bus.data_data_ok) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_timeout) begin
                    // An addr_ok arriving with the expiry does not buy an
                    // extra WAIT cycle; the abort fires on the limit.
                    w_expire    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (bus.data_addr_ok) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.data_data_ok) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_timeout) begin
                    w_expire    = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.longest_stall) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request fields and read-data register.
    // Request fields are latched once, when the request leaves IDLE. They
    // stay stable for the whole transaction, whatever the CPU does with its
    // inputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_latch) begin
                r_wr    <= w_wr;
                r_size  <= w_size;
                r_addr  <= {bus.data_sram_addr[ADDR_W-1:2], w_addr_lo};
                r_wdata <= bus.data_sram_wdata;
            end
            if (w_capture) begin
                r_rdata <= bus.data_rdata;
            end else if (w_expire) begin
                r_rdata <= 32'hDEAD_BEEF;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.data_req        = (r_state == ST_REQ);
    assign bus.data_wr         = r_wr;
    assign bus.data_size       = r_size;
    assign bus.data_addr       = r_addr;
    assign bus.data_wdata      = r_wdata;
    assign bus.data_sram_rdata = r_rdata;

    // DONE is the release cycle: the CPU may still hold en there, but the
    // access has completed, so it must not stall.
    assign bus.d_stall = bus.data_sram_en && (r_state != ST_DONE);

endmodule

// File: tb/tb_data_sram_like_bridge.sv
module tb_data_sram_like_bridge;

    logic clk;
    logic rst;
`ifdef DBRIDGE_TIMEOUT_EN
    logic bus_err;
`endif

    data_sram_like_bridge_if #(.ADDR_W(32)) bif ();

    data_sram_like_bridge #(
        .ADDR_W(32)
`ifdef DBRIDGE_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef DBRIDGE_TIMEOUT_EN
        .bus_err(bus_err),
`endif
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus_rdata;
        int          aok;       // REQ cycles without addr_ok before accepting
        int          dok;       // cycles after addr_ok until data_ok (0 = same)
        int          hold;      // DONE cycles with longest_stall held high
        bit          keep_en;   // CPU issues next access without dropping en
        logic        exp_wr;
        logic [1:0]  exp_size;
        logic [31:0] exp_addr;
        int          exp_stall;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    localparam int NVEC = 12;
    vec_t     vecs[NVEC];
    bus_exp_t sb[$];
    int       n_checks = 0;
    int       n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called when the bench sees data_req and answers with addr_ok.
    task automatic take_handshake();
        bus_exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL extra_req: got bus request at addr %h expected none", bif.data_addr);
        end else begin
            e = sb.pop_front();
            chk("bus_wr",    {31'd0, bif.data_wr},   {31'd0, e.wr});
            chk("bus_size",  {30'd0, bif.data_size}, {30'd0, e.size});
            chk("bus_addr",  bif.data_addr,          e.addr);
            chk("bus_wdata", bif.data_wdata,         e.wdata);
        end
    endtask

    task automatic run_access(input vec_t v);
        bus_exp_t    e;
        int          stalls;
        int          cyc;
        int          phase;
        int          cnt;
        bit          released;
        logic [31:0] held;
        stalls   = 0;
        cyc      = 0;
        phase    = 0;
        cnt      = 0;
        released = 1'b0;
        e.wr    = v.exp_wr;
        e.size  = v.exp_size;
        e.addr  = v.exp_addr;
        e.wdata = v.wdata;
        @(negedge clk);
        bif.data_sram_en    = 1'b1;
        bif.data_sram_wen   = v.wen;
        bif.data_sram_addr  = v.addr;
        bif.data_sram_wdata = v.wdata;
        bif.data_rdata      = v.bus_rdata;
        sb.push_back(e);
        while (!released && cyc < 60) begin
            #1;
            bif.data_addr_ok = 1'b0;
            bif.data_data_ok = 1'b0;
            if (!bif.d_stall) begin
                released = 1'b1;
            end else begin
                stalls++;
                case (phase)
                    0: begin
                        if (bif.data_req) begin
                            if (cnt == v.aok) begin
                                bif.data_addr_ok = 1'b1;
                                take_handshake();
                                if (v.dok == 0) begin
                                    bif.data_data_ok = 1'b1;
                                    phase = 2;
                                end else begin
                                    phase = 1;
                                    cnt   = 0;
                                end
                            end else begin
                                cnt++;
                            end
                        end
                    end
                    1: begin
                        chk("req_low_in_wait", {31'd0, bif.data_req}, 32'd0);
                        cnt++;
                        if (cnt == v.dok) begin
                            bif.data_data_ok = 1'b1;
                            phase = 2;
                        end
                    end
                    default: begin
                        chk("req_after_data_ok", {31'd0, bif.data_req}, 32'd0);
                    end
                endcase
            end
            if (!released) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!released) begin
            n_checks++;
            n_err++;
            $display("FAIL release_timeout: got d_stall still high after %0d cycles expected release", cyc);
        end
        chk("stall_cycles", stalls, v.exp_stall);
        chk("completed_before_release", phase, 2);
        chk("req_in_done", {31'd0, bif.data_req}, 32'd0);
        if (v.wen == 4'b0000) begin
            chk("rdata_done", bif.data_sram_rdata, v.bus_rdata);
        end
        held = bif.data_sram_rdata;
        if (v.hold > 0) begin
            bif.longest_stall = 1'b1;
            for (int k = 0; k < v.hold; k++) begin
                @(negedge clk);
                #1;
                // Stray bus responses while held in DONE must be ignored.
                bif.data_addr_ok = 1'b1;
                bif.data_data_ok = 1'b1;
                bif.data_rdata   = 32'hFFFF_0000 ^ k;
                chk("hold_no_stall", {31'd0, bif.d_stall},  32'd0);
                chk("hold_no_req",   {31'd0, bif.data_req}, 32'd0);
                chk("hold_rdata",    bif.data_sram_rdata,   held);
                if (k == v.hold - 1) begin
                    bif.longest_stall = 1'b0;
                end
            end
        end
        if (!v.keep_en) begin
            @(negedge clk);
            bif.data_sram_en  = 1'b0;
            bif.data_sram_wen = 4'b0000;
            bif.data_addr_ok  = 1'b0;
            bif.data_data_ok  = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench time limit");
    end

    initial begin
        //             wen      addr          wdata         bus_rdata     aok dok hold keep wr    size   exp_addr     stall
        vecs[0]  = '{4'b0000, 32'h1FC0_0010, 32'h0000_0000, 32'h1234_5678, 0, 1, 0, 1'b0, 1'b0, 2'd2, 32'h1FC0_0010, 3};
        vecs[1]  = '{4'b0100, 32'h8000_0004, 32'h00CC_0000, 32'h1111_1111, 1, 2, 0, 1'b0, 1'b1, 2'd0, 32'h8000_0006, 5};
        vecs[2]  = '{4'b0000, 32'h0000_1237, 32'h0000_0000, 32'hCAFE_F00D, 0, 0, 0, 1'b0, 1'b0, 2'd2, 32'h0000_1237, 2};
        vecs[3]  = '{4'b0000, 32'hA000_0100, 32'h0000_0000, 32'h0BAD_F00D, 0, 1, 4, 1'b1, 1'b0, 2'd2, 32'hA000_0100, 3};
        vecs[4]  = '{4'b1111, 32'h0000_0103, 32'hDEAD_0001, 32'h2222_2222, 2, 1, 0, 1'b0, 1'b1, 2'd2, 32'h0000_0100, 5};
        vecs[5]  = '{4'b0011, 32'h0000_0206, 32'h0000_BEEF, 32'h3333_3333, 0, 3, 0, 1'b0, 1'b1, 2'd1, 32'h0000_0204, 5};
        vecs[6]  = '{4'b1100, 32'h0000_0204, 32'hBEEF_0000, 32'h4444_4444, 1, 0, 0, 1'b0, 1'b1, 2'd1, 32'h0000_0206, 3};
        vecs[7]  = '{4'b0001, 32'h1000_0003, 32'h0000_00AA, 32'h5555_5555, 0, 1, 0, 1'b1, 1'b1, 2'd0, 32'h1000_0000, 3};
        vecs[8]  = '{4'b1000, 32'h1000_0000, 32'hAA00_0000, 32'h6666_6666, 0, 0, 0, 1'b1, 1'b1, 2'd0, 32'h1000_0003, 2};
        vecs[9]  = '{4'b0010, 32'h1000_0000, 32'h0000_AA00, 32'h7777_7777, 0, 1, 2, 1'b0, 1'b1, 2'd0, 32'h1000_0001, 3};
        vecs[10] = '{4'b0101, 32'h2000_0002, 32'h1234_5678, 32'h5A5A_5A5A, 0, 1, 0, 1'b0, 1'b1, 2'd2, 32'h2000_0000, 3};
        vecs[11] = '{4'b0000, 32'h3000_0002, 32'h0000_0000, 32'h8765_4321, 3, 1, 0, 1'b0, 1'b0, 2'd2, 32'h3000_0002, 6};

        rst                 = 1'b1;
        bif.data_sram_en    = 1'b0;
        bif.data_sram_wen   = 4'b0000;
        bif.data_sram_addr  = 32'd0;
        bif.data_sram_wdata = 32'd0;
        bif.longest_stall   = 1'b0;
        bif.data_addr_ok    = 1'b0;
        bif.data_data_ok    = 1'b0;
        bif.data_rdata      = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req",     {31'd0, bif.data_req},  32'd0);
        chk("rst_wr",      {31'd0, bif.data_wr},   32'd0);
        chk("rst_size",    {30'd0, bif.data_size}, 32'd0);
        chk("rst_addr",    bif.data_addr,          32'd0);
        chk("rst_wdata",   bif.data_wdata,         32'd0);
        chk("rst_rdata",   bif.data_sram_rdata,    32'd0);
        chk("rst_d_stall", {31'd0, bif.d_stall},   32'd0);
`ifdef DBRIDGE_TIMEOUT_EN
        chk("rst_bus_err", {31'd0, bus_err},       32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_access(vecs[i]);
        end

        // Reset while the read sits in WAIT; rdata still holds 0x87654321.
        @(negedge clk);
        begin
            bus_exp_t e;
            e.wr    = 1'b0;
            e.size  = 2'd2;
            e.addr  = 32'h4000_0008;
            e.wdata = 32'd0;
            sb.push_back(e);
        end
        bif.data_sram_en    = 1'b1;
        bif.data_sram_wen   = 4'b0000;
        bif.data_sram_addr  = 32'h4000_0008;
        bif.data_sram_wdata = 32'd0;
        bif.data_rdata      = 32'h0F0F_0F0F;
        #1;
        chk("rst_seq_idle_stall", {31'd0, bif.d_stall}, 32'd1);
        @(negedge clk);
        #1;
        chk("rst_seq_req", {31'd0, bif.data_req}, 32'd1);
        if (bif.data_req) begin
            take_handshake();
        end
        bif.data_addr_ok = 1'b1;
        @(negedge clk);
        #1;
        bif.data_addr_ok = 1'b0;
        chk("rst_seq_wait_req", {31'd0, bif.data_req}, 32'd0);
        chk("rst_seq_wait_stall", {31'd0, bif.d_stall}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mid_req",   {31'd0, bif.data_req}, 32'd0);
        chk("rst_mid_rdata", bif.data_sram_rdata,   32'd0);
        chk("rst_mid_addr",  bif.data_addr,         32'd0);
        chk("rst_mid_stall_en1", {31'd0, bif.d_stall}, 32'd1);
        bif.data_sram_en = 1'b0;
        #1;
        chk("rst_mid_stall_en0", {31'd0, bif.d_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Normal operation resumes after the reset.
        run_access(vecs[0]);

`ifdef DBRIDGE_TIMEOUT_EN
        // The bus never answers: the watchdog must release the pipeline.
        begin
            int stalls;
            int cyc;
            stalls = 0;
            cyc    = 0;
            @(negedge clk);
            bif.data_sram_en   = 1'b1;
            bif.data_sram_wen  = 4'b0000;
            bif.data_sram_addr = 32'h5000_0000;
            #1;
            while (bif.d_stall && cyc < 40) begin
                stalls++;
                @(negedge clk);
                #1;
                cyc++;
            end
            chk("to_stall_cycles", stalls, 9);
            chk("to_bus_err",      {31'd0, bus_err},   32'd1);
            chk("to_rdata",        bif.data_sram_rdata, 32'hDEAD_BEEF);
            chk("to_released",     {31'd0, bif.d_stall}, 32'd0);
            @(negedge clk);
            bif.data_sram_en = 1'b0;
            repeat (2) @(negedge clk);
            chk("to_bus_err_sticky", {31'd0, bus_err}, 32'd1);
        end
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
